// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS-7 generator/checker slice:
//   - polynomial tap positions for x^7 + x^6 + 1
//   - PRBS_SEED, the generator start state after reset
//   - chkState_t, the checker lock FSM state type
//   - prbsStep(), one LFSR step; the new bit lands in bit 0 of the result
// ---------------------------------------------------------------------------
package prbs_pkg;

  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } chkState_t;

  // One shift of the 7-bit register. The emitted bit is also the new LSB,
  // so callers read the output bit back as result[0].
  function automatic logic [6:0] prbsStep(input logic [6:0] s);
    logic b;
    b = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
    return {s[5:0], b};
  endfunction

endpackage

// File: rtl/prbs_step.sv
// ---------------------------------------------------------------------------
// prbs_step
// Combinational word stepper: advances a PRBS-7 state by DATA_W steps and
// assembles the emitted bits into one word, first bit in the MSB.
// Ports:
//   i_state  in   7       current LFSR state
//   o_state  out  7       state after DATA_W steps
//   o_word   out  DATA_W  emitted word
// ---------------------------------------------------------------------------
module prbs_step
  import prbs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [6:0]        i_state,
  output logic [6:0]        o_state,
  output logic [DATA_W-1:0] o_word
);

  logic [6:0] w_walk;

  // Walk the register DATA_W times. Shifting each new bit in from the right
  // leaves the earliest bit in the MSB once the loop completes.
  always_comb begin
    w_walk = i_state;
    o_word = '0;
    for (int k = 0; k < DATA_W; k++) begin
      w_walk = prbsStep(w_walk);
      o_word = {o_word[DATA_W-2:0], w_walk[0]};
    end
    o_state = w_walk;
  end

endmodule

// File: rtl/prbs_gen_check.sv
// ---------------------------------------------------------------------------
// prbs_gen_check
// PRBS-7 traffic generator with valid/ready output plus a loopback checker
// that self-synchronises on the returned stream and counts errored words.
// Ports:
//   clk, rstn       clock (rising edge) and synchronous active-low reset
//   en              generator enable
//   inject_err      pulse: flip bit 0 of the next word loaded for transmit
//   tx_data/valid   generated word and its valid flag
//   tx_ready        downstream accepts the current word
//   rx_data/valid   looped-back word; always accepted when valid
//   err_clr         clear err_cnt and err_sat (wins over an increment)
//   locked          checker is in LOCK
//   err_cnt         saturating errored-word count
//   err_sat         err_cnt has reached all-ones
// ---------------------------------------------------------------------------
module prbs_gen_check
  import prbs_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LOCK_CNT = 8,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              inject_err,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              err_clr,
  output logic              locked,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_sat
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] RUN_TARGET = CNT_W'(LOCK_CNT);

  // ---------------- generator ----------------
  logic [6:0]        r_genState;
  logic [6:0]        w_genNext;
  logic [DATA_W-1:0] w_genWord;
  logic [DATA_W-1:0] r_txData;
  logic              r_txValid;
  logic              r_armed;
  logic              w_load;

  prbs_step #(.DATA_W(DATA_W)) u_genStep (
    .i_state (r_genState),
    .o_state (w_genNext),
    .o_word  (w_genWord)
  );

  // A new word is loaded whenever the output slot is empty or being drained,
  // but only while enabled; a pending word is never replaced before it is
  // accepted, even if en drops.
  assign w_load = en && (!r_txValid || tx_ready);

  // The armed flag only corrupts the copy placed in tx_data; the LFSR keeps
  // its clean sequence. A pulse landing on the same edge as a load arms the
  // flag for the following word unless the flag was already armed, in which
  // case that pulse is absorbed by the load that consumes it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_genState <= PRBS_SEED;
      r_txData   <= '0;
      r_txValid  <= 1'b0;
      r_armed    <= 1'b0;
    end else if (w_load) begin
      r_genState <= w_genNext;
      r_txData   <= w_genWord ^ DATA_W'(r_armed);
      r_txValid  <= 1'b1;
      r_armed    <= inject_err & ~r_armed;
    end else begin
      if (r_txValid && tx_ready) r_txValid <= 1'b0;
      r_armed <= r_armed | inject_err;
    end
  end

  assign tx_data  = r_txData;
  assign tx_valid = r_txValid;

  // ---------------- checker ----------------
  chkState_t         r_state;
  chkState_t         w_stateNext;
  logic [6:0]        r_predState;
  logic [6:0]        w_predNext;
  logic [DATA_W-1:0] w_predWord;
  logic [CNT_W-1:0]  r_runCnt;
  logic [CNT_W-1:0]  w_runInc;
  logic              w_match;
  logic              w_runDone;
  logic              w_errHit;
  logic [ERR_W-1:0]  r_errCnt;
  logic [ERR_W-1:0]  w_errInc;
  logic              r_errSat;

  prbs_step #(.DATA_W(DATA_W)) u_predStep (
    .i_state (r_predState),
    .o_state (w_predNext),
    .o_word  (w_predWord)
  );

  assign w_match   = (rx_data == w_predWord);
  assign w_runInc  = r_runCnt + CNT_W'(1);
  assign w_runDone = (w_runInc == RUN_TARGET);
  assign w_errHit  = rx_valid && (r_state == LOCK) && !w_match;
  assign w_errInc  = r_errCnt + ERR_W'(1);

  // State register for the lock FSM.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= HUNT;
    else       r_state <= w_stateNext;
  end

  // Next-state logic; the FSM only moves on beats carrying rx_valid.
  always_comb begin
    w_stateNext = r_state;
    if (rx_valid) begin
      case (r_state)
        HUNT:    w_stateNext = SYNC;
        SYNC: begin
          if (!w_match)      w_stateNext = HUNT;
          else if (w_runDone) w_stateNext = LOCK;
        end
        LOCK: begin
          if (!w_match && w_runDone) w_stateNext = HUNT;
        end
        default: w_stateNext = HUNT;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    locked = 1'b0;
    if (r_state == LOCK) locked = 1'b1;
  end

  // Predictor and run counter. One counter serves both phases: in SYNC it
  // counts consecutive matches, in LOCK consecutive mismatches, and it
  // restarts from zero on every state change. Since a word of at least
  // seven bits ends with the seven newest LFSR bits, the low seven bits of
  // any received word are exactly the state that predicts the next one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_predState <= PRBS_SEED;
      r_runCnt    <= '0;
    end else if (rx_valid) begin
      case (r_state)
        HUNT: begin
          r_predState <= rx_data[6:0];
          r_runCnt    <= '0;
        end
        SYNC: begin
          r_predState <= w_predNext;
          r_runCnt    <= (w_match && !w_runDone) ? w_runInc : '0;
        end
        LOCK: begin
          r_predState <= w_predNext;
          r_runCnt    <= (w_match || w_runDone) ? '0 : w_runInc;
        end
        default: r_runCnt <= '0;
      endcase
    end
  end

  // Errored-word counter: clear wins, and once saturated it holds all-ones.
  always_ff @(posedge clk) begin
    if (!rstn || err_clr) begin
      r_errCnt <= '0;
      r_errSat <= 1'b0;
    end else if (w_errHit && !r_errSat) begin
      r_errCnt <= w_errInc;
      r_errSat <= &w_errInc;
    end
  end

  assign err_cnt = r_errCnt;
  assign err_sat = r_errSat;

endmodule

// File: tb/tb_prbs_gen_check.sv
// ---------------------------------------------------------------------------
// tb_prbs_gen_check
// Drives two copies of prbs_gen_check (default ERR_W and ERR_W=2) with the
// same stimulus and compares every output each cycle with a reference model
// built from the PRBS bit sequence itself, plus directed checks on the
// documented word values and lock/error milestones.
// ---------------------------------------------------------------------------
module tb_prbs_gen_check;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        inject_err;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        err_clr;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        locked;
  logic [15:0] err_cnt;
  logic        err_sat;

  logic [7:0]  txDataS;
  logic        txValidS;
  logic        lockedS;
  logic [1:0]  errCntS;
  logic        errSatS;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  prbs_gen_check dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .inject_err (inject_err),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_cnt    (err_cnt),
    .err_sat    (err_sat)
  );

  prbs_gen_check #(.ERR_W(2)) dutSat (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .inject_err (inject_err),
    .tx_data    (txDataS),
    .tx_valid   (txValidS),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .err_clr    (err_clr),
    .locked     (lockedS),
    .err_cnt    (errCntS),
    .err_sat    (errSatS)
  );

  // Reference sequence: seq[0..6] are the seed bits, seq[7+n] is output bit n,
  // each bit being the XOR of the bits 7 and 6 positions earlier.
  bit seq [0:133];

  // Reference model state.
  logic       mValid;
  logic [7:0] mData;
  int         genPos;
  logic       mArmed;
  int         mMode;      // 0 hunting, 1 syncing, 2 locked
  int         goodRun;
  int         badRun;
  int         predPos;
  logic       predZero;
  int         err16;
  logic       sat16;
  int         err2;
  logic       sat2;

  function automatic bit prbsBit(input int n);
    return seq[7 + (n % 127)];
  endfunction

  function automatic logic [7:0] seqWord(input int pos);
    logic [7:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) w = {w[6:0], prbsBit(pos + j)};
    return w;
  endfunction

  // Position in the sequence right after the 7-bit window equal to v.
  function automatic int seedPos(input logic [6:0] v);
    logic [6:0] c;
    for (int p = 0; p < 127; p++) begin
      c = '0;
      for (int j = 0; j < 7; j++) c = {c[5:0], prbsBit(p + 120 + j)};
      if (c == v) return p;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mValid = 1'b0; mData = '0; genPos = 0; mArmed = 1'b0;
    mMode = 0; goodRun = 0; badRun = 0; predPos = 0; predZero = 1'b0;
    err16 = 0; sat16 = 1'b0; err2 = 0; sat2 = 1'b0;
  endtask

  task automatic modelStep();
    logic       hit;
    logic       load;
    logic [7:0] want;
    int         p;
    if (!rstn) begin
      modelReset();
      return;
    end
    hit = 1'b0;
    if (rx_valid) begin
      want = predZero ? 8'h00 : seqWord(predPos);
      if (mMode == 0) begin
        p = seedPos(rx_data[6:0]);
        predZero = (p < 0);
        predPos  = (p < 0) ? 0 : p;
        mMode = 1; goodRun = 0;
      end else if (mMode == 1) begin
        predPos = (predPos + 8) % 127;
        if (rx_data == want) begin
          goodRun++;
          if (goodRun == 8) begin mMode = 2; badRun = 0; end
        end else begin
          mMode = 0;
        end
      end else begin
        predPos = (predPos + 8) % 127;
        if (rx_data != want) begin
          hit = 1'b1;
          badRun++;
          if (badRun == 8) mMode = 0;
        end else begin
          badRun = 0;
        end
      end
    end
    if (err_clr) begin
      err16 = 0; sat16 = 1'b0; err2 = 0; sat2 = 1'b0;
    end else if (hit) begin
      if (err16 < 65535) err16++;
      sat16 = (err16 == 65535);
      if (err2 < 3) err2++;
      sat2 = (err2 == 3);
    end
    load = en && (!mValid || tx_ready);
    if (load) begin
      mData  = seqWord(genPos) ^ {7'b0, mArmed};
      genPos = (genPos + 8) % 127;
      mValid = 1'b1;
      mArmed = inject_err && !mArmed;
    end else begin
      if (mValid && tx_ready) mValid = 1'b0;
      mArmed = mArmed || inject_err;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // rxMode: 0 idle, 1 loopback, 2 loopback beat carrying rxForce,
  // 3 unconditional beat carrying rxForce.
  task automatic applyStimulus(input logic iEn, input logic iReady, input logic iInject,
                               input logic iClr, input int rxMode, input logic [7:0] rxForce);
    en         = iEn;
    tx_ready   = iReady;
    inject_err = iInject;
    err_clr    = iClr;
    case (rxMode)
      1:       begin rx_valid = mValid && iReady; rx_data = mData;   end
      2:       begin rx_valid = mValid && iReady; rx_data = rxForce; end
      3:       begin rx_valid = 1'b1;             rx_data = rxForce; end
      default: begin rx_valid = 1'b0;             rx_data = 8'($urandom); end
    endcase
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("txValid",  32'(tx_valid), 32'(mValid));
    checkOutput("txData",   32'(tx_data),  32'(mData));
    checkOutput("locked",   32'(locked),   32'(mMode == 2));
    checkOutput("errCnt",   32'(err_cnt),  32'(err16));
    checkOutput("errSat",   32'(err_sat),  32'(sat16));
    checkOutput("txDataS",  32'(txDataS),  32'(mData));
    checkOutput("lockedS",  32'(lockedS),  32'(mMode == 2));
    checkOutput("errCntS",  32'(errCntS),  32'(err2));
    checkOutput("errSatS",  32'(errSatS),  32'(sat2));
  endtask

  initial begin
    logic [7:0] injWant;
    logic       rEn, rReady, rInj, rClr;
    int         sel;
    int         rMode;
    logic [7:0] rForce;

    seq[0:6] = '{default: 1'b1};
    for (int i = 7; i < 134; i++) seq[i] = seq[i-7] ^ seq[i-6];
    modelReset();

    rstn = 1'b0; en = 1'b0; inject_err = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = '0; err_clr = 1'b0;

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checkOutput("rstTxValid", 32'(tx_valid), 32'h0);
    checkOutput("rstTxData",  32'(tx_data),  32'h0);
    checkOutput("rstLocked",  32'(locked),   32'h0);
    checkOutput("rstErrCnt",  32'(err_cnt),  32'h0);
    checkOutput("rstErrSat",  32'(err_sat),  32'h0);

    $display("[TB] sequence");
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("firstValid", 32'(tx_valid), 32'h1);
    checkOutput("firstWord",  32'(tx_data),  32'h02);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("secondWord", 32'(tx_data),  32'h0C);

    $display("[TB] backpressure");
    rstn = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00);
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("bpFirst", 32'(tx_data), 32'h02);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h00);
      checkOutput("bpHold",  32'(tx_data),  32'h02);
      checkOutput("bpValid", 32'(tx_valid), 32'h1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("bpRelease", 32'(tx_data), 32'h0C);

    $display("[TB] lock and injection");
    repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("notYetLocked", 32'(locked), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("lockAfter9", 32'(locked), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h00);
    injWant = seqWord(genPos) ^ 8'h01;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("injWord", 32'(tx_data), 32'(injWant));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("injErrCnt", 32'(err_cnt), 32'h1);
    checkOutput("injLocked", 32'(locked),  32'h1);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("injErrHold", 32'(err_cnt), 32'h1);

    $display("[TB] loss of lock");
    repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2, 8'hFF);
    checkOutput("lol7Locked", 32'(locked),  32'h1);
    checkOutput("lol7ErrCnt", 32'(err_cnt), 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2, 8'hFF);
    checkOutput("lolUnlocked", 32'(locked),  32'h0);
    checkOutput("lolErrCnt",   32'(err_cnt), 32'h9);
    checkOutput("lolErrCntS",  32'(errCntS), 32'h3);
    checkOutput("lolErrSatS",  32'(errSatS), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1, 8'h00);
    checkOutput("clrErrCnt", 32'(err_cnt), 32'h0);
    checkOutput("clrErrSatS", 32'(errSatS), 32'h0);
    repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("relockPending", 32'(locked), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("relocked", 32'(locked), 32'h1);

    $display("[TB] saturation");
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2, 8'hFF);
    checkOutput("satErrCntS", 32'(errCntS), 32'h3);
    checkOutput("satErrSatS", 32'(errSatS), 32'h1);
    checkOutput("satErrCnt",  32'(err_cnt), 32'h5);
    checkOutput("satLocked",  32'(locked),  32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2, 8'hFF);
    checkOutput("clrWinsS",   32'(errCntS), 32'h0);
    checkOutput("clrWinsSat", 32'(errSatS), 32'h0);
    checkOutput("clrWins",    32'(err_cnt), 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("satStillLocked", 32'(locked), 32'h1);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      rEn    = ($urandom_range(0, 99) < 85);
      rReady = ($urandom_range(0, 99) < 70);
      rInj   = ($urandom_range(0, 99) < 4);
      rClr   = ($urandom_range(0, 99) < 2);
      sel    = $urandom_range(0, 99);
      rForce = 8'($urandom);
      if (sel < 75) begin
        rMode = 1;
      end else if (sel < 87) begin
        rMode  = 2;
        rForce = mData ^ 8'(1 << $urandom_range(0, 7));
      end else if (sel < 95) begin
        rMode = 0;
      end else begin
        rMode = 3;
      end
      applyStimulus(rEn, rReady, rInj, rClr, rMode, rForce);
    end

    $display("[TB] reset during operation");
    repeat (30) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("preRstLocked", 32'(locked), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("preRstPending", 32'(tx_valid), 32'h1);
    rstn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00);
    checkOutput("midRstTxValid", 32'(tx_valid), 32'h0);
    checkOutput("midRstTxData",  32'(tx_data),  32'h0);
    checkOutput("midRstLocked",  32'(locked),   32'h0);
    checkOutput("midRstErrCnt",  32'(err_cnt),  32'h0);
    checkOutput("midRstErrSat",  32'(err_sat),  32'h0);
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("postRstWord", 32'(tx_data), 32'h02);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h00);
    checkOutput("postRstWord2", 32'(tx_data), 32'h0C);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
